pptx_arbiter: RTL and testbench
===============================

# pptx_arbiter

Packet-locked round-robin arbiter that shares the single pport transmit channel (stb/data/busy toward the Pi) among NREQ byte-stream requesters, such as the line-echo buffer and a status/message generator. A grant is held for a whole line, so output lines never interleave. The grant is released on the end-of-line byte, at a maximum length, or after an idle timeout. The block sits between the requesters and the pport transmit interface and adds one cycle of grant latency per line.

## Interface
- NREQ, 2: number of requesters, 2..4.
- MAXLEN, 80: maximum bytes per grant, 1..255.
- TIMEOUT, 1023: consecutive cycles a granted requester may leave i_stb low before its grant is revoked, 1..65535.
- EOL, 8'h0a: byte value that ends a line and releases the grant.
- i_clk  in  1  sole clock.
- i_reset_n  in  1  reset; synchronous, active-low.
- i_stb  in  NREQ  per-requester byte valid.
- i_data  in  8*NREQ  requester k byte in bits [8k+7:8k].
- o_busy  out  NREQ  per-requester stall; a byte is accepted when i_stb[k] && !o_busy[k].
- o_tx_stb  out  1  to pport transmit strobe.
- o_tx_data  out  8  to pport transmit data.
- i_tx_busy  in  1  from pport; a byte is taken when o_tx_stb && !i_tx_busy.
- o_active  out  1  a grant is held.
- o_owner  out  2  index of the current or most recent grantee.

## Operation
- The arbiter has two states, IDLE and GRANT.
- IDLE:
  - o_tx_stb=0 and all o_busy bits are 1.
  - If any i_stb bit is set, pick the first asserted requester scanning from (last+1) mod NREQ with wraparound.
  - Register that pick as the grantee g, clear cnt and idle, and go to GRANT on the next edge.
- GRANT:
  - o_tx_stb=i_stb[g], o_tx_data=i_data[g], o_busy[g]=i_tx_busy; every other o_busy bit is 1.
  - These paths are combinational from the registered g; there is no data register.
  - On acceptance (i_stb[g] && !i_tx_busy): cnt increments and idle clears.
    - If the accepted byte equals EOL, or cnt == MAXLEN-1 (this is the MAXLEN-th byte), set last=g and go to IDLE.
  - If i_stb[g]=0: idle increments. When idle == TIMEOUT-1, set last=g and go to IDLE.
  - If i_stb[g]=1 but i_tx_busy=1: idle holds its value. Backpressure is not idleness.
- Widths: cnt is 8 bits and idle is 16 bits, both unsigned. Neither may wrap, because the release conditions fire first.
- Boundary cases:
  - EOL arriving as the MAXLEN-th byte gives a single release, not two.
  - Acceptance and the timeout threshold in the same cycle: acceptance wins and idle clears.
  - A requester whose grant is revoked must keep holding its byte. It is re-arbitrated fairly, with no priority boost.
  - A sole requester may be re-granted immediately after release; the one IDLE cycle still occurs.
  - With NREQ<4, o_owner upper bits are 0 and the scan ignores unused indices.
- Reset (i_reset_n=0 at an edge):
  - Go to IDLE with cnt=0, idle=0, last=NREQ-1 so that requester 0 wins first.
  - o_tx_stb=0, o_busy all 1, o_active=0, o_owner=0.
  - Reset mid-line drops the partial line at the arbiter; requesters own any resend.

## Timing
- From i_stb rising in IDLE to o_tx_stb high takes 1 cycle.
- Steady state is one byte per cycle while !i_tx_busy, i.e. zero-bubble within a line.
- Releasing the grant costs exactly 1 IDLE cycle before the next grant.
- o_active is registered and high exactly in GRANT. o_owner is registered and updates on entry to GRANT.
- No combinational path exists from i_stb to o_busy except through the registered g.

## Structure
- Shared package pp_pkg holds:
  - the state enum (PP_IDLE, PP_GRANT);
  - the default EOL constant 8'h0a;
  - the CR constant 8'h0d, reserved for future use.
- One sub-module, pp_rrpick, is natural: a combinational round-robin priority pick with inputs req[NREQ] and last, and outputs pick and any. It is reusable by the future receive-side demux.
- Target size is about 150–250 lines of RTL.

## Test plan
- Single requester:
  - Req0 sends "hi\n" with i_tx_busy=0.
  - Expected: o_tx_data shows 68,69,0a on consecutive cycles starting 1 cycle after i_stb; then o_active drops; o_busy[1] stays 1 throughout.
- Contention:
  - Req0 and req1 both assert in the same cycle, each with a 3-byte line ending in 0a.
  - Expected: req0's line goes out first, then 1 IDLE cycle, then req1's line. There is no interleaving and o_owner reads 0 then 1.
- MAXLEN:
  - Req1 streams 100 bytes of 41 with no EOL.
  - Expected: release after the 80th byte; req0, if waiting, is granted next; the remaining 20 bytes follow in a later grant.
- Backpressure and timeout:
  - Step 1: hold i_tx_busy=1 for 2000 cycles with i_stb[0]=1. Expected: no timeout and the grant is held.
  - Step 2: drop i_stb[0] for 1023 cycles. Expected: the grant is revoked exactly at cycle 1023; at 1022 it is still held.
- Simultaneous events:
  - Case 1: EOL accepted as the 80th byte. Expected: a single release.
  - Case 2: acceptance lands on cycle TIMEOUT-1. Expected: no timeout.
- Reset mid-line:
  - Drive i_reset_n=0 for 1 cycle during byte 3 of req1's line.
  - Expected: next cycle o_tx_stb=0, o_busy=all 1s, o_owner=0; with both requesting afterwards, req0 is granted first.

Source files
------------

// File: rtl/pp_pkg.sv
// Shared definitions for the pport transmit-side arbiter and its helpers.
// Holds the arbiter state encoding, line-delimiter constants and the owner index width.
package pp_pkg;

   typedef enum logic {
      PP_IDLE  = 1'b0,
      PP_GRANT = 1'b1
   } pp_state_t;

   localparam logic [7:0] PP_EOL = 8'h0a;
   // Carriage return, kept alongside EOL for later CR/LF-aware framing.
   localparam logic [7:0] PP_CR  = 8'h0d;

   localparam int PP_OWNER_W = 2;

endpackage

// File: rtl/pp_rrpick.sv
// Combinational round-robin priority pick: first asserted request after 'last', with wraparound.
// Shared by the transmit arbiter and, later, the receive-side demux.
module pp_rrpick
   import pp_pkg::*;
#(
   parameter int NREQ = 2
)(
   input  logic [NREQ-1:0]       req,
   input  logic [PP_OWNER_W-1:0] last,
   output logic [PP_OWNER_W-1:0] pick,
   output logic                  any
);

   logic [NREQ-1:0] above;
   logic [NREQ-1:0] req_hi;

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_above
         assign above[gi] = (PP_OWNER_W'(gi) > last);
      end
   endgenerate

   assign req_hi = req & above;
   assign any    = |req;

   // Lowest index above 'last' wins; otherwise wrap to the lowest index overall.
   always_comb begin
      pick = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req[i]) pick = PP_OWNER_W'(i);
      end
      if (|req_hi) begin
         for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_hi[i]) pick = PP_OWNER_W'(i);
         end
      end
   end

endmodule

// File: rtl/pptx_arbiter.sv
// Packet-locked round-robin arbiter sharing the pport transmit channel among NREQ byte streams.
// A grant lasts one line: released on EOL, at MAXLEN bytes, or after TIMEOUT quiet cycles.
module pptx_arbiter
   import pp_pkg::*;
#(
   parameter int         NREQ    = 2,
   parameter int         MAXLEN  = 80,
   parameter int         TIMEOUT = 1023,
   parameter logic [7:0] EOL     = PP_EOL
)(
   input  logic                  i_clk,
   input  logic                  i_reset_n,
   input  logic [NREQ-1:0]       i_stb,
   input  logic [8*NREQ-1:0]     i_data,
   output logic [NREQ-1:0]       o_busy,
   output logic                  o_tx_stb,
   output logic [7:0]            o_tx_data,
   input  logic                  i_tx_busy,
   output logic                  o_active,
   output logic [PP_OWNER_W-1:0] o_owner
);

   pp_state_t             state_reg, state_next;
   logic [PP_OWNER_W-1:0] g_reg, g_next;
   logic [PP_OWNER_W-1:0] last_reg, last_next;
   logic [7:0]            cnt_reg, cnt_next;
   logic [15:0]           idle_reg, idle_next;

   logic [NREQ-1:0]       sel;
   logic                  stb_g;
   logic [7:0]            data_g;
   logic                  accept;
   logic [PP_OWNER_W-1:0] pick;
   logic                  pick_any;

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_sel
         assign sel[gi] = (g_reg == PP_OWNER_W'(gi));
      end
   endgenerate

   // Grantee byte path is a pure mux on the registered owner; no data staging.
   always_comb begin
      data_g = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (sel[k]) data_g = i_data[8*k +: 8];
      end
   end

   assign stb_g  = |(i_stb & sel);
   assign accept = stb_g && !i_tx_busy;

   pp_rrpick #(.NREQ(NREQ)) u_pick (
      .req  (i_stb),
      .last (last_reg),
      .pick (pick),
      .any  (pick_any)
   );

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state_reg <= PP_IDLE;
         g_reg     <= '0;
         last_reg  <= PP_OWNER_W'(NREQ - 1);
         cnt_reg   <= '0;
         idle_reg  <= '0;
      end else begin
         state_reg <= state_next;
         g_reg     <= g_next;
         last_reg  <= last_next;
         cnt_reg   <= cnt_next;
         idle_reg  <= idle_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      g_next     = g_reg;
      last_next  = last_reg;
      cnt_next   = cnt_reg;
      idle_next  = idle_reg;
      case (state_reg)
         PP_IDLE: begin
            if (pick_any) begin
               state_next = PP_GRANT;
               g_next     = pick;
               cnt_next   = '0;
               idle_next  = '0;
            end
         end
         PP_GRANT: begin
            // Acceptance is checked first so a byte landing on the timeout threshold keeps the grant.
            if (accept) begin
               cnt_next  = cnt_reg + 8'd1;
               idle_next = '0;
               if (data_g == EOL || cnt_reg == 8'(MAXLEN - 1)) begin
                  state_next = PP_IDLE;
                  last_next  = g_reg;
               end
            end else if (!stb_g) begin
               idle_next = idle_reg + 16'd1;
               if (idle_reg == 16'(TIMEOUT - 1)) begin
                  state_next = PP_IDLE;
                  last_next  = g_reg;
               end
            end
         end
         default: state_next = PP_IDLE;
      endcase
   end

   always_comb begin
      o_tx_stb = 1'b0;
      o_busy   = '1;
      if (state_reg == PP_GRANT) begin
         o_tx_stb = stb_g;
         o_busy   = ~sel | {NREQ{i_tx_busy}};
      end
   end

   assign o_tx_data = data_g;
   assign o_active  = (state_reg == PP_GRANT);
   assign o_owner   = g_reg;

endmodule

// File: tb/tb_pptx_arbiter.sv
// Self-checking bench for pptx_arbiter: queue-driven requesters, a line-level reference model
// compared every cycle, and hand-computed checks for the timing and boundary cases.
module tb_pptx_arbiter;

   localparam int         NREQ    = 2;
   localparam int         MAXLEN  = 80;
   localparam int         TIMEOUT = 1023;
   localparam logic [7:0] EOL     = 8'h0a;

   logic              clk     = 1'b0;
   logic              reset_n = 1'b0;
   logic [NREQ-1:0]   stb     = '0;
   logic [8*NREQ-1:0] data    = '0;
   logic              tx_busy = 1'b0;
   logic [NREQ-1:0]   busy;
   logic              tx_stb;
   logic [7:0]        tx_data;
   logic              active;
   logic [1:0]        owner;

   always #5 clk = ~clk;

   pptx_arbiter #(
      .NREQ    (NREQ),
      .MAXLEN  (MAXLEN),
      .TIMEOUT (TIMEOUT),
      .EOL     (EOL)
   ) dut (
      .i_clk     (clk),
      .i_reset_n (reset_n),
      .i_stb     (stb),
      .i_data    (data),
      .o_busy    (busy),
      .o_tx_stb  (tx_stb),
      .o_tx_data (tx_data),
      .i_tx_busy (tx_busy),
      .o_active  (active),
      .o_owner   (owner)
   );

   int          tests = 0;
   int          fails = 0;
   bit          chk_en = 1'b0;
   int unsigned busy_pct = 0;
   int unsigned pause_pct = 0;
   logic [NREQ-1:0] mask = '1;
   logic [7:0]  q0[$];
   logic [7:0]  q1[$];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
      end
   endtask

   task automatic negs(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input int k, input logic [7:0] b);
      if (k == 0) q0.push_back(b);
      else        q1.push_back(b);
   endtask

   task automatic push_random_line(input int k);
      int len;
      len = int'($urandom_range(120, 1));
      for (int i = 0; i < len - 1; i++) begin
         logic [7:0] b;
         b = 8'($urandom_range(255));
         push(k, b);
      end
      push(k, EOL);
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while ((q0.size() != 0 || q1.size() != 0 || active !== 1'b0) && n < 20000) begin
         @(negedge clk);
         n++;
      end
      check(name, 32'(n < 20000), 32'd1);
   endtask

   // Requesters: present the head byte, hold it until accepted, optionally pause.
   initial begin
      forever begin
         @(posedge clk);
         if (stb[0] && !busy[0] && q0.size() != 0) void'(q0.pop_front());
         if (stb[1] && !busy[1] && q1.size() != 0) void'(q1.pop_front());
         #1;
         stb[0]     = (q0.size() != 0) && mask[0] && ($urandom_range(99) >= pause_pct);
         stb[1]     = (q1.size() != 0) && mask[1] && ($urandom_range(99) >= pause_pct);
         data[7:0]  = (q0.size() != 0) ? q0[0] : 8'h00;
         data[15:8] = (q1.size() != 0) ? q1[0] : 8'h00;
         tx_busy    = ($urandom_range(99) < busy_pct);
      end
   end

   // Reference model: who owns the channel, bytes sent in this line, quiet cycles so far.
   bit         m_active = 1'b0;
   int         m_owner  = 0;
   int         m_last   = NREQ - 1;
   int         m_bytes  = 0;
   int         m_quiet  = 0;
   logic [7:0] m_cur;

   function automatic int rr_pick(input int last, input logic [NREQ-1:0] req);
      for (int d = 1; d <= NREQ; d++) begin
         int k;
         k = (last + d) % NREQ;
         if (req[k]) return k;
      end
      return 0;
   endfunction

   always @(posedge clk) begin
      if (!reset_n) begin
         m_active = 1'b0;
         m_owner  = 0;
         m_last   = NREQ - 1;
         m_bytes  = 0;
         m_quiet  = 0;
      end else if (!m_active) begin
         if (stb != '0) begin
            m_owner  = rr_pick(m_last, stb);
            m_active = 1'b1;
            m_bytes  = 0;
            m_quiet  = 0;
         end
      end else begin
         m_cur = data[8*m_owner +: 8];
         if (stb[m_owner] && !tx_busy) begin
            m_bytes++;
            m_quiet = 0;
            if (m_cur == EOL || m_bytes == MAXLEN) begin
               $display("[TB] line req%0d %0d bytes (%s)", m_owner, m_bytes,
                        (m_cur == EOL) ? "eol" : "maxlen");
               m_last   = m_owner;
               m_active = 1'b0;
            end
         end else if (!stb[m_owner]) begin
            m_quiet++;
            if (m_quiet == TIMEOUT) begin
               $display("[TB] line req%0d %0d bytes (timeout)", m_owner, m_bytes);
               m_last   = m_owner;
               m_active = 1'b0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         logic [NREQ-1:0] eb;
         logic            es;
         es = m_active && stb[m_owner];
         eb = '1;
         if (m_active) eb[m_owner] = tx_busy;
         check("cyc_active", 32'(active), 32'(m_active));
         check("cyc_owner",  32'(owner),  32'(m_owner));
         check("cyc_tx_stb", 32'(tx_stb), 32'(es));
         check("cyc_busy",   32'(busy),   32'(eb));
         if (es) check("cyc_tx_data", 32'(tx_data), 32'(data[8*m_owner +: 8]));
      end
   end

   initial begin
      reset_n = 1'b0;
      negs(3);
      chk_en = 1'b1;
      check("reset_active", 32'(active), 32'd0);
      check("reset_busy",   32'(busy),   32'b11);
      check("reset_tx_stb", 32'(tx_stb), 32'd0);
      check("reset_owner",  32'(owner),  32'd0);
      reset_n = 1'b1;
      negs(1);

      // Contention: both lines queued at once, req0 first after reset.
      push(0, 8'h61); push(0, 8'h62); push(0, EOL);
      push(1, 8'h63); push(1, 8'h64); push(1, EOL);
      negs(1); check("cont_idle", 32'(tx_stb), 32'd0);
      negs(1); check("cont_owner0", 32'(owner), 32'd0);
               check("cont_byte0", 32'(tx_data), 32'h61);
      negs(2); check("cont_eol0", 32'(tx_data), 32'h0a);
      negs(1); check("cont_gap", 32'(active), 32'd0);
      negs(1); check("cont_owner1", 32'(owner), 32'd1);
               check("cont_byte1", 32'(tx_data), 32'h63);
      negs(2); check("cont_eol1", 32'(tx_data), 32'h0a);
      negs(1); check("cont_done", 32'(active), 32'd0);

      // Single requester sends "hi\n".
      push(0, 8'h68); push(0, 8'h69); push(0, EOL);
      negs(1); check("hi_idle", 32'(tx_stb), 32'd0);
      negs(1); check("hi_h", 32'(tx_data), 32'h68);
               check("hi_busy", 32'(busy), 32'b10);
      negs(1); check("hi_i", 32'(tx_data), 32'h69);
      negs(1); check("hi_eol", 32'(tx_data), 32'h0a);
               check("hi_busy1", 32'(busy[1]), 32'd1);
      negs(1); check("hi_release", 32'(active), 32'd0);

      // MAXLEN split: req1 streams 100 bytes while req0 waits.
      for (int i = 0; i < 100; i++) push(1, 8'h41);
      push(0, 8'h78); push(0, 8'h79); push(0, EOL);
      negs(2);  check("max_owner1", 32'(owner), 32'd1);
      negs(79); check("max_80th", 32'(tx_stb), 32'd1);
      negs(1);  check("max_release", 32'(active), 32'd0);
      negs(1);  check("max_next_owner", 32'(owner), 32'd0);
                check("max_next_byte", 32'(tx_data), 32'h78);
      drain("max_drain");

      // Backpressure holds the grant; a quiet requester loses it after TIMEOUT cycles.
      busy_pct = 100;
      push(0, 8'h7a); push(0, EOL);
      negs(2);    check("bp_granted", 32'(tx_stb), 32'd1);
      negs(2000); check("bp_held", 32'(active), 32'd1);
      mask[0] = 1'b0;
      busy_pct = 0;
      negs(1022); check("to_1022", 32'(active), 32'd1);
      negs(1);    check("to_1023", 32'(active), 32'd1);
      negs(1);    check("to_revoked", 32'(active), 32'd0);
      mask[0] = 1'b1;
      drain("to_drain");

      // EOL as the MAXLEN-th byte releases once.
      for (int i = 0; i < 79; i++) push(1, 8'h41);
      push(1, EOL);
      negs(81); check("sim_eol80", 32'(tx_data), 32'h0a);
      negs(1);  check("sim_release", 32'(active), 32'd0);
      negs(1);  check("sim_stay_idle", 32'(active), 32'd0);

      // A byte accepted on the last quiet cycle keeps the grant.
      busy_pct = 100;
      push(0, 8'h71);
      negs(2); check("acc_granted", 32'(tx_stb), 32'd1);
      mask[0] = 1'b0;
      busy_pct = 0;
      negs(1022); check("acc_held", 32'(active), 32'd1);
      mask[0] = 1'b1;
      negs(1); check("acc_byte", 32'(tx_data), 32'h71);
      negs(1); check("acc_wins", 32'(active), 32'd1);
      push(0, EOL);
      drain("acc_drain");

      // Reset in the middle of req1's line.
      push(1, 8'h61); push(1, 8'h62); push(1, 8'h63); push(1, 8'h64);
      push(1, 8'h65); push(1, 8'h66); push(1, EOL);
      negs(4); check("rst_byte3", 32'(tx_data), 32'h63);
      push(0, 8'h78); push(0, 8'h79); push(0, EOL);
      reset_n = 1'b0;
      negs(1); check("rst_tx_stb", 32'(tx_stb), 32'd0);
               check("rst_busy", 32'(busy), 32'b11);
               check("rst_owner", 32'(owner), 32'd0);
      reset_n = 1'b1;
      negs(1); check("rst_regrant", 32'(owner), 32'd0);
               check("rst_regrant_act", 32'(active), 32'd1);
      drain("rst_drain");

      // Randomized traffic with backpressure and requester pauses.
      busy_pct  = 25;
      pause_pct = 15;
      for (int c = 0; c < 2500; c++) begin
         @(negedge clk);
         if (q0.size() < 40 && $urandom_range(9) == 0) push_random_line(0);
         if (q1.size() < 40 && $urandom_range(9) == 0) push_random_line(1);
      end
      pause_pct = 0;
      drain("rand_drain");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
